// File: rtl/core_ctrl.sv
`timescale 1ns/1ps
// RV32I multi-cycle control sequencer: FETCH/DECODE/EXECUTE/WRITEBACK, 4 cycles per instruction plus fetch wait.
// Fetch stalls on imem_ack indefinitely; an unsupported encoding parks the core in TRAP until reset.
module core_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [3:0]  alu_ops,
    output logic        is_lui,
    output logic        is_i_type,
    output logic        is_branch,
    output logic [31:0] imm,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    input  logic        alu_pc_load,
    input  logic [31:0] alu_new_pc,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_armed;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic [3:0]  r_alu_ops;
    logic        r_is_lui;
    logic        r_is_i;
    logic        r_is_br;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_wr;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [3:0]  w_dec_ops;
    logic        w_dec_lui;
    logic        w_dec_i;
    logic        w_dec_br;
    logic [31:0] w_dec_imm;
    logic        w_dec_ill;
    logic        w_dec_wr;

    assign w_opcode = r_instr[6:0];
    assign w_f3     = r_instr[14:12];
    assign w_f7     = r_instr[31:25];

    always_comb begin
        w_dec_ops = 4'd0;
        w_dec_lui = 1'b0;
        w_dec_i   = 1'b0;
        w_dec_br  = 1'b0;
        w_dec_imm = 32'd0;
        w_dec_ill = 1'b0;
        case (w_opcode)
            OP_R: begin
                case ({w_f7, w_f3})
                    {7'b0000000, 3'b000}: w_dec_ops = 4'b0000;
                    {7'b0000000, 3'b001}: w_dec_ops = 4'b0101;
                    {7'b0000000, 3'b010}: w_dec_ops = 4'b1001;
                    {7'b0000000, 3'b100}: w_dec_ops = 4'b0010;
                    {7'b0000000, 3'b101}: w_dec_ops = 4'b0110;
                    {7'b0000000, 3'b110}: w_dec_ops = 4'b0011;
                    {7'b0000000, 3'b111}: w_dec_ops = 4'b0100;
                    {7'b0100000, 3'b000}: w_dec_ops = 4'b0001;
                    {7'b0000001, 3'b000}: w_dec_ops = 4'b1100;
                    {7'b0000001, 3'b100}: w_dec_ops = 4'b1101;
                    default:              w_dec_ill = 1'b1;
                endcase
            end
            OP_I: begin
                w_dec_i   = 1'b1;
                w_dec_imm = {{20{r_instr[31]}}, r_instr[31:20]};
                case (w_f3)
                    3'b000:  w_dec_ops = 4'b0000;
                    3'b100:  w_dec_ops = 4'b0010;
                    3'b010:  w_dec_ops = 4'b1000;
                    3'b011:  w_dec_ops = 4'b1011;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            OP_B: begin
                w_dec_br  = 1'b1;
                w_dec_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                             r_instr[30:25], r_instr[11:8], 1'b0};
                case (w_f3)
                    3'b000:  w_dec_ops = 4'b0000;
                    3'b001:  w_dec_ops = 4'b0001;
                    3'b100:  w_dec_ops = 4'b0010;
                    3'b101:  w_dec_ops = 4'b0011;
                    default: w_dec_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                // The ALU applies the 12-bit shift; we hand it the raw upper field.
                w_dec_lui = 1'b1;
                w_dec_imm = {12'd0, r_instr[31:12]};
            end
            default: w_dec_ill = 1'b1;
        endcase
    end

    assign w_dec_wr = !w_dec_ill && !w_dec_br && (r_instr[11:7] != 5'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (r_armed) w_next = S_FETCH;
            S_FETCH:     if (imem_ack) w_next = S_DECODE;
            S_DECODE:    w_next = w_dec_ill ? S_TRAP : S_EXECUTE;
            S_EXECUTE:   w_next = S_WRITEBACK;
            S_WRITEBACK: w_next = S_FETCH;
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_IDLE;
        endcase
    end

    // r_armed holds IDLE for one full clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'd0;
        end else if (r_state == S_FETCH && imem_ack) begin
            r_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_ops <= 4'd0;
            r_is_lui  <= 1'b0;
            r_is_i    <= 1'b0;
            r_is_br   <= 1'b0;
            r_imm     <= 32'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_wr      <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_alu_ops <= w_dec_ops;
            r_is_lui  <= w_dec_lui;
            r_is_i    <= w_dec_i;
            r_is_br   <= w_dec_br;
            r_imm     <= w_dec_imm;
            r_rs1     <= r_instr[19:15];
            r_rs2     <= r_instr[24:20];
            r_rd      <= r_instr[11:7];
            r_wr      <= w_dec_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_instret <= 32'd0;
        end else if (r_state == S_WRITEBACK) begin
            r_pc      <= (r_is_br && alu_pc_load) ? alu_new_pc : r_pc + 32'd4;
            r_instret <= r_instret + 32'd1;
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instret   = r_instret;
    assign alu_ops   = r_alu_ops;
    assign is_lui    = r_is_lui;
    assign is_i_type = r_is_i;
    assign is_branch = r_is_br;
    assign imm       = r_imm;
    assign rs1_addr  = r_rs1;
    assign rs2_addr  = r_rs2;
    assign rd_addr   = r_rd;
    assign rd_we     = (r_state == S_WRITEBACK) && r_wr;
    assign illegal   = (r_state == S_TRAP);

endmodule
